icache_refill_ctrl: RTL and testbench

Line-refill responder on the memory side of the fetch-stage instruction cache. Accepts one miss request per line from the cache and reads the whole line word-by-word from backing instruction memory, modelling a fixed per-word latency. Streams each word back to the cache as a fill beat and holds the fetch stage stalled until the line is complete. Sits between the cache and instruction memory; its stall output gates the PC enable.

---
 rtl/icache_refill_ctrl.sv | 146 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller: reads a full line word-by-word from backing memory
// with a fixed per-word latency, streams fill beats, and stalls fetch. Macro ICACHE_REFILL_CWF_EN enables critical-word-first.
module icache_refill_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_done,
    output logic                  stall,
    output logic [1:0]            dbg_state
);

    // Handshake: a request is taken in any cycle where req_valid && req_ready && !flush;
    // req_valid while req_ready is low is ignored, nothing is queued.

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W = IDX_W + 2;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [LAT_W-1:0]      LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0]      LAST_BEAT  = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~(ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state,     w_state_next;
    logic [ADDR_WIDTH-1:0] r_line_base, w_line_base_next;
    logic [IDX_W-1:0]      r_word_idx,  w_word_idx_next;
    logic [IDX_W-1:0]      r_beats,     w_beats_next;
    logic [LAT_W-1:0]      r_lat_cnt,   w_lat_cnt_next;

    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [IDX_W-1:0]      w_start_idx;

    // Word index is OR-ed into the cleared offset bits, so the address can never leave the line.
    assign w_mem_addr = r_line_base | {{(ADDR_WIDTH - OFF_W){1'b0}}, r_word_idx, 2'b00};

`ifdef ICACHE_REFILL_CWF_EN
    assign w_start_idx = req_addr[OFF_W-1:2];
`else
    assign w_start_idx = '0;
`endif

    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_line_base <= '0;
            r_word_idx  <= '0;
            r_beats     <= '0;
            r_lat_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_line_base <= w_line_base_next;
            r_word_idx  <= w_word_idx_next;
            r_beats     <= w_beats_next;
            r_lat_cnt   <= w_lat_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_line_base_next = r_line_base;
        w_word_idx_next  = r_word_idx;
        w_beats_next     = r_beats;
        w_lat_cnt_next   = r_lat_cnt;
        req_ready        = 1'b0;
        mem_addr         = '0;
        fill_valid       = 1'b0;
        fill_addr        = '0;
        fill_data        = '0;
        fill_done        = 1'b0;
        stall            = 1'b0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid && !flush;
                if (req_valid && !flush) begin
                    w_state_next     = S_WAIT;
                    w_line_base_next = req_addr & LINE_MASK;
                    w_word_idx_next  = w_start_idx;
                    w_beats_next     = '0;
                    w_lat_cnt_next   = LAT_RELOAD;
                end
            end
            S_WAIT: begin
                stall    = 1'b1;
                mem_addr = w_mem_addr;
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (r_lat_cnt == '0) begin
                    fill_valid      = 1'b1;
                    fill_addr       = w_mem_addr;
                    fill_data       = mem_rdata;
                    w_word_idx_next = r_word_idx + IDX_W'(1);
                    w_beats_next    = r_beats + IDX_W'(1);
                    if (r_beats == LAST_BEAT) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_lat_cnt_next = LAT_RELOAD;
                    end
                end else begin
                    w_lat_cnt_next = r_lat_cnt - LAT_W'(1);
                end
            end
            S_DONE: begin
                stall        = 1'b1;
                fill_done    = !flush;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Reset is synchronous, so the state may still be busy while it is held; silence everything.
        if (reset) begin
            req_ready  = 1'b0;
            mem_addr   = '0;
            fill_valid = 1'b0;
            fill_addr  = '0;
            fill_data  = '0;
            fill_done  = 1'b0;
            stall      = 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1,
// both against a combinational memory model, with beat expectations held in per-instance queues.
module tb_icache_refill_ctrl;

    logic        clk;
    logic        reset      [2];
    logic        flush      [2];
    logic        req_valid  [2];
    logic [31:0] req_addr   [2];
    logic        req_ready  [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_rdata  [2];
    logic        fill_valid [2];
    logic [31:0] fill_addr  [2];
    logic [31:0] fill_data  [2];
    logic        fill_done  [2];
    logic        stall      [2];
    logic [1:0]  dbg_state  [2];

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    int          n_tests;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    assign mem_rdata[0] = mem_word(mem_addr[0]);
    assign mem_rdata[1] = mem_word(mem_addr[1]);

    icache_refill_ctrl #(.MEM_LATENCY(2)) dut0 (
        .clk(clk), .reset(reset[0]), .flush(flush[0]), .req_valid(req_valid[0]),
        .req_addr(req_addr[0]), .req_ready(req_ready[0]), .mem_addr(mem_addr[0]),
        .mem_rdata(mem_rdata[0]), .fill_valid(fill_valid[0]), .fill_addr(fill_addr[0]),
        .fill_data(fill_data[0]), .fill_done(fill_done[0]), .stall(stall[0]),
        .dbg_state(dbg_state[0])
    );

    icache_refill_ctrl #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset[1]), .flush(flush[1]), .req_valid(req_valid[1]),
        .req_addr(req_addr[1]), .req_ready(req_ready[1]), .mem_addr(mem_addr[1]),
        .mem_rdata(mem_rdata[1]), .fill_valid(fill_valid[1]), .fill_addr(fill_addr[1]),
        .fill_data(fill_data[1]), .fill_done(fill_done[1]), .stall(stall[1]),
        .dbg_state(dbg_state[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // k-th beat address of the line holding addr (4 words per line).
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int k);
        logic [1:0] start;
        logic [1:0] idx;
`ifdef ICACHE_REFILL_CWF_EN
        start = addr[3:2];
`else
        start = 2'd0;
`endif
        idx = start + 2'(k);
        return (addr & ~32'hF) | {28'd0, idx, 2'b00};
    endfunction

    task automatic push_beat(input int u, input logic [31:0] addr, input int k);
        logic [31:0] a;
        a = beat_addr(addr, k);
        if (u == 0) exp_q0.push_back({a, mem_word(a)});
        else        exp_q1.push_back({a, mem_word(a)});
    endtask

    task automatic expect_cycle(input int u, input string tag, input logic ev, input logic ed,
                                input logic es, input logic er);
        logic [63:0] e;
        logic        have;
        @(negedge clk);
        n_tests++;
        assert (fill_valid[u] === ev) else begin
            n_fail++;
            $error("FAIL %s fill_valid got %b exp %b", tag, fill_valid[u], ev);
        end
        n_tests++;
        assert (fill_done[u] === ed) else begin
            n_fail++;
            $error("FAIL %s fill_done got %b exp %b", tag, fill_done[u], ed);
        end
        n_tests++;
        assert (stall[u] === es) else begin
            n_fail++;
            $error("FAIL %s stall got %b exp %b", tag, stall[u], es);
        end
        n_tests++;
        assert (req_ready[u] === er) else begin
            n_fail++;
            $error("FAIL %s req_ready got %b exp %b", tag, req_ready[u], er);
        end
        if (er) begin
            n_tests++;
            assert (mem_addr[u] === 32'd0) else begin
                n_fail++;
                $error("FAIL %s idle mem_addr got %h exp 0", tag, mem_addr[u]);
            end
        end
        if (fill_valid[u] === 1'b1) begin
            have = 1'b0;
            e    = '0;
            if (u == 0 && exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                have = 1'b1;
            end else if (u == 1 && exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                have = 1'b1;
            end
            n_tests++;
            assert (have && ({fill_addr[u], fill_data[u]} === e)) else begin
                n_fail++;
                $error("FAIL %s beat got addr %h data %h exp addr %h data %h (queued %b)",
                       tag, fill_addr[u], fill_data[u], e[63:32], e[31:0], have);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int u, input string tag);
        logic [99:0] obs;
        @(negedge clk);
        obs = {req_ready[u], fill_valid[u], fill_done[u], stall[u],
               mem_addr[u], fill_addr[u], fill_data[u]};
        n_tests++;
        assert (obs === 100'd0) else begin
            n_fail++;
            $error("FAIL %s outputs in reset got %h exp 0", tag, obs);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input int u, input string tag);
        int n;
        n = (u == 0) ? exp_q0.size() : exp_q1.size();
        n_tests++;
        assert (n === 0) else begin
            n_fail++;
            $error("FAIL %s beats still expected got %0d exp 0", tag, n);
        end
    endtask

    // Full line: request cycle T, beats every lat cycles, fill_done at T+4*lat+1.
    task automatic do_line(input int u, input string tag, input logic [31:0] addr, input int lat,
                           input bit hold, input logic [31:0] hold_addr, input bit flush_done);
        for (int k = 0; k < 4; k++) begin
            if (!flush_done || k < 4) push_beat(u, addr, k);
        end
        req_valid[u] = 1'b1;
        req_addr[u]  = addr;
        expect_cycle(u, {tag, "_req"}, 1'b0, 1'b0, 1'b1, 1'b1);
        req_valid[u] = hold;
        req_addr[u]  = hold ? hold_addr : 32'd0;
        for (int c = 1; c <= 4 * lat; c++) begin
            expect_cycle(u, {tag, "_wait"}, (c % lat) == 0, 1'b0, 1'b1, 1'b0);
        end
        flush[u] = flush_done;
        expect_cycle(u, {tag, "_done"}, 1'b0, !flush_done, 1'b1, 1'b0);
        flush[u] = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int u = 0; u < 2; u++) begin
            reset[u]     = 1'b1;
            flush[u]     = 1'b0;
            req_valid[u] = 1'b0;
            req_addr[u]  = 32'd0;
        end
        @(posedge clk);
        #1;
        check_reset(0, "por0");
        check_reset(1, "por1");
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        expect_cycle(0, "post_reset0", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle(1, "post_reset1", 1'b0, 1'b0, 1'b0, 1'b1);

        // Basic line at latency 2.
        do_line(0, "t1", 32'h0000_0104, 2, 1'b0, 32'd0, 1'b0);
        expect_cycle(0, "t1_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check_empty(0, "t1_q");

        // Latency 1 at the top of a line: back-to-back beats, no address past 0xFFC.
        do_line(1, "t3", 32'h0000_0FFC, 1, 1'b0, 32'd0, 1'b0);
        expect_cycle(1, "t3_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check_empty(1, "t3_q");

        // Flush on the second beat cycle.
        push_beat(0, 32'h0000_0088, 0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0088;
        expect_cycle(0, "t4_req", 1'b0, 1'b0, 1'b1, 1'b1);
        req_valid[0] = 1'b0;
        expect_cycle(0, "t4_w1", 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle(0, "t4_b0", 1'b1, 1'b0, 1'b1, 1'b0);
        expect_cycle(0, "t4_w3", 1'b0, 1'b0, 1'b1, 1'b0);
        flush[0] = 1'b1;
        expect_cycle(0, "t4_flush", 1'b0, 1'b0, 1'b1, 1'b0);
        flush[0] = 1'b0;
        for (int i = 0; i < 6; i++) expect_cycle(0, "t4_after", 1'b0, 1'b0, 1'b0, 1'b1);
        check_empty(0, "t4_q");

        // Flush together with a request in IDLE: not accepted.
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0500;
        flush[0]     = 1'b1;
        expect_cycle(0, "flush_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        for (int i = 0; i < 3; i++) expect_cycle(0, "flush_idle_after", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset at T+3, then a clean line at 0x200.
        push_beat(0, 32'h0000_0040, 0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_0040;
        expect_cycle(0, "t5_req", 1'b0, 1'b0, 1'b1, 1'b1);
        req_valid[0] = 1'b0;
        expect_cycle(0, "t5_w1", 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle(0, "t5_b0", 1'b1, 1'b0, 1'b1, 1'b0);
        reset[0] = 1'b1;
        check_reset(0, "t5_reset");
        reset[0] = 1'b0;
        expect_cycle(0, "t5_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle(0, "t5_idle2", 1'b0, 1'b0, 1'b0, 1'b1);
        check_empty(0, "t5_q");
        do_line(0, "t5_line", 32'h0000_0200, 2, 1'b0, 32'd0, 1'b0);
        expect_cycle(0, "t5_line_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check_empty(0, "t5_line_q");

        // Request held through a refill with a new address: taken once IDLE.
        do_line(0, "t6a", 32'h0000_0184, 2, 1'b1, 32'h0000_0300, 1'b0);
        check_empty(0, "t6a_q");
        do_line(0, "t6b", 32'h0000_0300, 2, 1'b0, 32'd0, 1'b0);
        expect_cycle(0, "t6_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check_empty(0, "t6_q");

        // Flush landing on the DONE cycle suppresses fill_done.
        do_line(1, "t7", 32'h1234_5678, 1, 1'b0, 32'd0, 1'b1);
        expect_cycle(1, "t7_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_cycle(1, "t7_idle2", 1'b0, 1'b0, 1'b0, 1'b1);
        check_empty(1, "t7_q");

        // Random line addresses at latency 1.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            ra = {$urandom_range(32'hFFFF, 0), $urandom_range(32'hFFFF, 0)} & ~32'h3;
            do_line(1, "rand", ra, 1, 1'b0, 32'd0, 1'b0);
            expect_cycle(1, "rand_idle", 1'b0, 1'b0, 1'b0, 1'b1);
            check_empty(1, "rand_q");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
